// File: rtl/spatial_encoder_par.sv
// HDC spatial encoder: rule-90 CA item memory, LANES channels accumulated per cycle, sign threshold.
// Optional per-channel mask (ChannelMask_SI) is built when SPATIAL_MASK_EN is defined.
module spatial_encoder_par #(
  parameter int unsigned INPUT_CHANNELS = 4,
  parameter int unsigned CHANNEL_WIDTH  = 16,
  parameter int unsigned HV_DIMENSION   = 1000,
  parameter int unsigned LANES          = 1,
  parameter int unsigned MODE_WIDTH     = 2,
  parameter int unsigned LABEL_WIDTH    = 5,
  parameter logic [0:HV_DIMENSION-1] CA_SEED = {1'b1, {(HV_DIMENSION-1){1'b0}}}
) (
  input  logic                                    Clk_CI,
  input  logic                                    Reset_RBI,
  input  logic                                    ValidIn_SI,
  output logic                                    ReadyOut_SO,
  input  logic [CHANNEL_WIDTH*INPUT_CHANNELS-1:0] ChannelsIn_DI,
  input  logic [MODE_WIDTH-1:0]                   ModeIn_SI,
  input  logic [LABEL_WIDTH-1:0]                  LabelIn_DI,
`ifdef SPATIAL_MASK_EN
  input  logic [INPUT_CHANNELS-1:0]               ChannelMask_SI,
`endif
  output logic                                    ValidOut_SO,
  input  logic                                    ReadyIn_SI,
  output logic [MODE_WIDTH-1:0]                   ModeOut_SO,
  output logic [LABEL_WIDTH-1:0]                  LabelOut_DO,
  output logic [0:HV_DIMENSION-1]                 HypervectorOut_DO
);

  localparam int unsigned G  = (INPUT_CHANNELS + LANES - 1) / LANES;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned AW = CHANNEL_WIDTH + $clog2(INPUT_CHANNELS) + 1;
  localparam logic [GW-1:0] LAST_GROUP = GW'(G - 1);
  localparam logic signed [AW-1:0] ACC_ZERO = {AW{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, THRESH = 2'd2, OUT = 2'd3} stateT;

  stateT State_SP, State_SN;
  logic                      capture_S;
  logic                      readyOut_S;
  logic [GW-1:0]             Grp_DP;
  logic [0:HV_DIMENSION-1]   Ca_DP, caNext_D;
  logic [CHANNEL_WIDTH-1:0]  Chan_DP [INPUT_CHANNELS];
  logic [MODE_WIDTH-1:0]     Mode_DP, ModeOut_DP;
  logic [LABEL_WIDTH-1:0]    Label_DP, LabelOut_DP;
  logic [INPUT_CHANNELS-1:0] Mask_SP;
  logic signed [AW-1:0]      Acc_DP [HV_DIMENSION];
  logic signed [AW-1:0]      grpSum_D [HV_DIMENSION];
  logic [0:HV_DIMENSION-1]   laneItem_D [LANES];
  logic signed [AW-1:0]      laneFeat_D [LANES];
  logic [0:HV_DIMENSION-1]   Hv_DP;

  // Rule-90 step with wrap-around neighbours.
  function automatic logic [0:HV_DIMENSION-1] caStep(input logic [0:HV_DIMENSION-1] s);
    logic [0:HV_DIMENSION-1] n;
    for (int d = 0; d < HV_DIMENSION; d++) begin
      n[d] = s[(d + HV_DIMENSION - 1) % HV_DIMENSION] ^ s[(d + 1) % HV_DIMENSION];
    end
    return n;
  endfunction

  // Item vectors of the current group's lanes and the CA state for the next group.
  always_comb begin
    logic [0:HV_DIMENSION-1] caTmp;
    caTmp = Ca_DP;
    for (int l = 0; l < LANES; l++) begin
      laneItem_D[l] = caTmp;
      caTmp         = caStep(caTmp);
    end
    caNext_D = caTmp;
  end

  // Feature of each lane; channels outside the current group, past the end, or masked give 0.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      laneFeat_D[l] = ACC_ZERO;
    end
    for (int c = 0; c < INPUT_CHANNELS; c++) begin
      if ((int'(Grp_DP) == c / LANES) && Mask_SP[c]) begin
        laneFeat_D[c % LANES] = $signed({{(AW-CHANNEL_WIDTH){1'b0}}, Chan_DP[c]});
      end else begin
        laneFeat_D[c % LANES] = laneFeat_D[c % LANES];
      end
    end
  end

  // Signed per-dimension sum of the current group.
  always_comb begin
    for (int d = 0; d < HV_DIMENSION; d++) begin
      logic signed [AW-1:0] sumTmp;
      sumTmp = ACC_ZERO;
      for (int l = 0; l < LANES; l++) begin
        if (laneItem_D[l][d]) begin
          sumTmp = sumTmp + laneFeat_D[l];
        end else begin
          sumTmp = sumTmp - laneFeat_D[l];
        end
      end
      grpSum_D[d] = sumTmp;
    end
  end

  // Next-state and handshake decode; ReadyOut follows ReadyIn only while presenting a result.
  always_comb begin
    State_SN   = State_SP;
    readyOut_S = 1'b0;
    capture_S  = 1'b0;
    case (State_SP)
      IDLE: begin
        readyOut_S = 1'b1;
        if (ValidIn_SI) begin
          capture_S = 1'b1;
          State_SN  = ACCUM;
        end else begin
          State_SN  = IDLE;
        end
      end
      ACCUM: begin
        if (Grp_DP == LAST_GROUP) begin
          State_SN = THRESH;
        end else begin
          State_SN = ACCUM;
        end
      end
      THRESH: State_SN = OUT;
      OUT: begin
        readyOut_S = ReadyIn_SI;
        if (ReadyIn_SI && ValidIn_SI) begin
          capture_S = 1'b1;
          State_SN  = ACCUM;
        end else if (ReadyIn_SI) begin
          State_SN  = IDLE;
        end else begin
          State_SN  = OUT;
        end
      end
      default: State_SN = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) State_SP <= IDLE;
    else            State_SP <= State_SN;
  end

  // Frame capture, CA/group advance, accumulation and result registers.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      Grp_DP      <= {GW{1'b0}};
      Ca_DP       <= {HV_DIMENSION{1'b0}};
      Mode_DP     <= {MODE_WIDTH{1'b0}};
      Label_DP    <= {LABEL_WIDTH{1'b0}};
      ModeOut_DP  <= {MODE_WIDTH{1'b0}};
      LabelOut_DP <= {LABEL_WIDTH{1'b0}};
      Hv_DP       <= {HV_DIMENSION{1'b0}};
      for (int c = 0; c < INPUT_CHANNELS; c++) Chan_DP[c] <= {CHANNEL_WIDTH{1'b0}};
      for (int d = 0; d < HV_DIMENSION; d++)   Acc_DP[d]  <= ACC_ZERO;
    end else begin
      if (capture_S) begin
        for (int c = 0; c < INPUT_CHANNELS; c++) begin
          Chan_DP[c] <= ChannelsIn_DI[CHANNEL_WIDTH*c +: CHANNEL_WIDTH];
        end
        Mode_DP  <= ModeIn_SI;
        Label_DP <= LabelIn_DI;
        Ca_DP    <= CA_SEED;
        Grp_DP   <= {GW{1'b0}};
      end else if (State_SP == ACCUM) begin
        Ca_DP  <= caNext_D;
        Grp_DP <= Grp_DP + GW'(1);
      end
      if (State_SP == ACCUM) begin
        for (int d = 0; d < HV_DIMENSION; d++) begin
          Acc_DP[d] <= (Grp_DP == {GW{1'b0}}) ? grpSum_D[d] : Acc_DP[d] + grpSum_D[d];
        end
      end
      if (State_SP == THRESH) begin
        for (int d = 0; d < HV_DIMENSION; d++) Hv_DP[d] <= (Acc_DP[d] > ACC_ZERO);
        ModeOut_DP  <= Mode_DP;
        LabelOut_DP <= Label_DP;
      end
    end
  end

`ifdef SPATIAL_MASK_EN
  // Channel mask captured with the frame.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI)     Mask_SP <= {INPUT_CHANNELS{1'b0}};
    else if (capture_S) Mask_SP <= ChannelMask_SI;
  end
`else
  assign Mask_SP = {INPUT_CHANNELS{1'b1}};
`endif

  assign ReadyOut_SO       = readyOut_S;
  assign ValidOut_SO       = (State_SP == OUT);
  assign ModeOut_SO        = ModeOut_DP;
  assign LabelOut_DO       = LabelOut_DP;
  assign HypervectorOut_DO = Hv_DP;

endmodule

// File: tb/tb_spatial_encoder_par.sv
// Scoreboard bench for spatial_encoder_par: D=8, two channels, LANES=1 (dutA) and LANES=2 (dutB).
module tb_spatial_encoder_par;
  localparam int D = 8, N = 2, CW = 16, MW = 2, LW = 5;

  typedef struct {
    logic [MW-1:0]  mode;
    logic [LW-1:0]  label;
    logic [0:D-1]   hv;
  } entT;

  logic Clk_CI = 1'b0, Reset_RBI = 1'b0, validIn = 1'b0, readyIn = 1'b0;
  logic [CW*N-1:0] chans = '0;
  logic [MW-1:0] mode = '0;
  logic [LW-1:0] label = '0;
  logic [N-1:0] mask = '0;
  logic readyOutA, validOutA, readyOutB, validOutB;
  logic [MW-1:0] modeOutA, modeOutB;
  logic [LW-1:0] labelOutA, labelOutB;
  logic [0:D-1] hvA, hvB;

  int numChecks = 0, numFails = 0, cyc = 0, capA = 0, capB = 0;
  logic prevA = 1'b0, prevB = 1'b0;
  entT qA[$], qB[$];
  logic [0:D-1] curHv;
  logic [MW-1:0] curMode;
  logic [LW-1:0] curLabel;

  spatial_encoder_par #(.INPUT_CHANNELS(N), .CHANNEL_WIDTH(CW), .HV_DIMENSION(D), .LANES(1),
                        .MODE_WIDTH(MW), .LABEL_WIDTH(LW)) dutA (
    .Clk_CI(Clk_CI), .Reset_RBI(Reset_RBI), .ValidIn_SI(validIn), .ReadyOut_SO(readyOutA),
    .ChannelsIn_DI(chans), .ModeIn_SI(mode), .LabelIn_DI(label),
`ifdef SPATIAL_MASK_EN
    .ChannelMask_SI(mask),
`endif
    .ValidOut_SO(validOutA), .ReadyIn_SI(readyIn), .ModeOut_SO(modeOutA),
    .LabelOut_DO(labelOutA), .HypervectorOut_DO(hvA));

  spatial_encoder_par #(.INPUT_CHANNELS(N), .CHANNEL_WIDTH(CW), .HV_DIMENSION(D), .LANES(2),
                        .MODE_WIDTH(MW), .LABEL_WIDTH(LW)) dutB (
    .Clk_CI(Clk_CI), .Reset_RBI(Reset_RBI), .ValidIn_SI(validIn), .ReadyOut_SO(readyOutB),
    .ChannelsIn_DI(chans), .ModeIn_SI(mode), .LabelIn_DI(label),
`ifdef SPATIAL_MASK_EN
    .ChannelMask_SI(mask),
`endif
    .ValidOut_SO(validOutB), .ReadyIn_SI(readyIn), .ModeOut_SO(modeOutB),
    .LabelOut_DO(labelOutB), .HypervectorOut_DO(hvB));

  always #5 Clk_CI = ~Clk_CI;
  always @(posedge Clk_CI) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference: walk the rule-90 item sequence from bit 0, sum signed features, threshold > 0.
  function automatic logic [0:D-1] expHv(input logic [CW*N-1:0] ch, input logic [N-1:0] mk);
    logic [0:D-1] im, nx, res;
    int sum [D];
    im = '0;
    im[0] = 1'b1;
    for (int d = 0; d < D; d++) sum[d] = 0;
    for (int c = 0; c < N; c++) begin
      for (int d = 0; d < D; d++) begin
        if (mk[c]) sum[d] += im[d] ? int'(ch[CW*c +: CW]) : -int'(ch[CW*c +: CW]);
      end
      for (int d = 0; d < D; d++) nx[d] = im[(d + D - 1) % D] ^ im[(d + 1) % D];
      im = nx;
    end
    for (int d = 0; d < D; d++) res[d] = (sum[d] > 0);
    return res;
  endfunction

  function automatic logic [N-1:0] effMask(input logic [N-1:0] mk);
`ifdef SPATIAL_MASK_EN
    return mk;
`else
    return {N{1'b1}};
`endif
  endfunction

  // Scoreboard: push on capture, pop and compare on output handshake, check latency.
  always @(negedge Clk_CI) begin
    entT e;
    if (!Reset_RBI) begin
      qA.delete(); qB.delete();
      prevA = 1'b0; prevB = 1'b0;
    end else begin
      if (validOutA && !prevA) checkVal("latA", cyc - capA, 3);
      if (validOutB && !prevB) checkVal("latB", cyc - capB, 2);
      prevA = validOutA; prevB = validOutB;
      if (validOutA && readyIn) begin
        checkVal("qA", qA.size(), 1);
        if (qA.size() > 0) begin
          e = qA.pop_front();
          checkVal("hvA", hvA, e.hv); checkVal("modeA", modeOutA, e.mode);
          checkVal("labelA", labelOutA, e.label);
        end
      end
      if (validOutB && readyIn) begin
        checkVal("qB", qB.size(), 1);
        if (qB.size() > 0) begin
          e = qB.pop_front();
          checkVal("hvB", hvB, e.hv); checkVal("modeB", modeOutB, e.mode);
          checkVal("labelB", labelOutB, e.label);
        end
      end
      e.mode = mode; e.label = label; e.hv = expHv(chans, effMask(mask));
      if (validIn && readyOutA) begin qA.push_back(e); capA = cyc + 1; end
      if (validIn && readyOutB) begin qB.push_back(e); capB = cyc + 1; end
    end
  end

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic sendFrame(input logic [CW-1:0] f0, input logic [CW-1:0] f1, input logic [MW-1:0] m,
                           input logic [LW-1:0] l, input logic [N-1:0] mk, input logic withReady);
    chans = {f1, f0}; mode = m; label = l; mask = mk;
    validIn = 1'b1; readyIn = withReady;
    curHv = expHv({f1, f0}, effMask(mk)); curMode = m; curLabel = l;
    tick();
    validIn = 1'b0; readyIn = 1'b0;
  endtask

  task automatic waitValidA();
    for (int i = 0; i < 20 && !validOutA; i++) tick();
    checkVal("waitValidA", validOutA, 1);
  endtask

  task automatic releaseOut();
    readyIn = 1'b1;
    tick();
    readyIn = 1'b0;
    checkVal("idleRdyA", readyOutA, 1);
    checkVal("idleValA", validOutA, 0);
  endtask

  initial begin
    logic [0:D-1] hv35;
    hv35 = 8'b01000001;
    #3;
    checkVal("rstRdyA", readyOutA, 1); checkVal("rstValA", validOutA, 0);
    checkVal("rstHvA", hvA, 0); checkVal("rstModeA", modeOutA, 0); checkVal("rstLblA", labelOutA, 0);
    checkVal("rstValB", validOutB, 0); checkVal("rstHvB", hvB, 0);
    tick(); tick();
    Reset_RBI = 1'b1;
    tick();

    // Worked example, then held output with ignored upstream pulses.
    sendFrame(16'd3, 16'd5, 2'd2, 5'd17, 2'b11, 1'b0);
    waitValidA();
    checkVal("hv35A", hvA, hv35); checkVal("hv35B", hvB, hv35);
    for (int i = 0; i < 10; i++) begin
      validIn = i[0]; chans = $urandom; mode = mode + 2'd1; label = label + 5'd3; mask = 2'b01;
      tick();
      checkVal("holdHvA", hvA, curHv); checkVal("holdRdyA", readyOutA, 0);
      checkVal("holdValA", validOutA, 1); checkVal("holdModeA", modeOutA, curMode);
      checkVal("holdLblA", labelOutA, curLabel); checkVal("holdHvB", hvB, curHv);
      checkVal("holdRdyB", readyOutB, 0);
    end
    validIn = 1'b0;
    releaseOut();

    // Random frames, mostly back-to-back with the previous result's handshake.
    for (int k = 0; k < 8; k++) begin
      sendFrame(CW'($urandom), CW'($urandom_range(0, 300)), MW'($urandom), LW'($urandom),
                2'b11, (k > 0));
      waitValidA();
      checkVal("rndHvA", hvA, curHv);
      repeat ($urandom_range(0, 2)) tick();
    end
    releaseOut();

`ifdef SPATIAL_MASK_EN
    sendFrame(16'd3, 16'd5, 2'd1, 5'd4, 2'b10, 1'b0);
    waitValidA();
    checkVal("mask10A", hvA, hv35); checkVal("mask10B", hvB, hv35);
    releaseOut();
    sendFrame(16'd3, 16'd5, 2'd1, 5'd5, 2'b00, 1'b0);
    waitValidA();
    checkVal("mask00A", hvA, 0); checkVal("mask00B", hvB, 0);
    releaseOut();
    sendFrame(16'd3, 16'd5, 2'd3, 5'd6, 2'b01, 1'b0);
    waitValidA();
    checkVal("mask01A", hvA, 8'b10000000);
    releaseOut();
`endif

    // Reset during accumulation aborts the frame; the next frame restarts from the seed.
    sendFrame(16'd900, 16'd7, 2'd3, 5'd9, 2'b11, 1'b0);
    #2 Reset_RBI = 1'b0;
    #1;
    checkVal("abortValA", validOutA, 0); checkVal("abortHvA", hvA, 0);
    checkVal("abortRdyA", readyOutA, 1); checkVal("abortValB", validOutB, 0);
    tick();
    Reset_RBI = 1'b1;
    tick();
    sendFrame(16'd3, 16'd5, 2'd2, 5'd30, 2'b11, 1'b0);
    waitValidA();
    checkVal("postRstA", hvA, hv35); checkVal("postRstB", hvB, hv35);
    releaseOut();
    tick();

    checkVal("drainA", qA.size(), 0); checkVal("drainB", qB.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end
endmodule

// File: doc/spatial_encoder_par.md
Name: spatial_encoder_par

Overview:
- Parametrised next-generation HDC spatial encoder. Sits between the feature front end and the temporal encoder.
- Captures one frame of per-channel features with mode and label, and generates each channel's item hypervector on the fly with a rule-90 cellular automaton.
- Per dimension, accumulates a signed feature-weighted sum across channels, LANES channels per cycle, and thresholds the sum to one binary hypervector.
- Output handshake supports back-to-back frames and an optional per-channel mask.

Parameters:
INPUT_CHANNELS, 4, number of input channels (>=1)
CHANNEL_WIDTH, 16, unsigned feature width per channel
HV_DIMENSION, 1000, hypervector length D
LANES, 1, channels processed per accumulate cycle (1..INPUT_CHANNELS)
MODE_WIDTH, 2, mode tag width
LABEL_WIDTH, 5, label tag width
CA_SEED, {D{1'b0}} with bit 0 set, item hypervector of channel 0

Ports:
Clk_CI  in  1  clock
Reset_RBI  in  1  asynchronous active-low reset
ValidIn_SI  in  1  upstream frame valid
ReadyOut_SO  out  1  encoder can accept a frame
ChannelsIn_DI  in  CHANNEL_WIDTH*INPUT_CHANNELS  channel c at bits [CHANNEL_WIDTH*c +: CHANNEL_WIDTH]
ModeIn_SI  in  MODE_WIDTH  mode tag
LabelIn_DI  in  LABEL_WIDTH  label tag
ChannelMask_SI  in  INPUT_CHANNELS  1 = channel contributes (present only with SPATIAL_MASK_EN)
ValidOut_SO  out  1  result valid
ReadyIn_SI  in  1  downstream ready
ModeOut_SO  out  MODE_WIDTH  captured mode
LabelOut_DO  out  LABEL_WIDTH  captured label
HypervectorOut_DO  out  [0:HV_DIMENSION-1]  encoded hypervector, bit d = dimension d

Behaviour:
- Reset (async assert, sync deassert): state IDLE; ReadyOut_SO=1; ValidOut_SO=0. Mode, label, hypervector, accumulators, group counter and CA register all 0; CA register reloads CA_SEED on first capture.
- Item memory: IM_0 = CA_SEED. IM_{c+1}[d] = IM_c[(d-1) mod D] XOR IM_c[(d+1) mod D]. Per cycle the CA advances LANES steps through a combinational chain.
- Accumulator per dimension: signed, width CHANNEL_WIDTH+clog2(INPUT_CHANNELS)+1.
  - Each active channel c adds +feature_c if IM_c[d]=1 and -feature_c if IM_c[d]=0.
  - Output bit d = 1 iff the sum is > 0. A tie (0) gives 0.
- Groups: G = ceil(INPUT_CHANNELS/LANES). Group g holds channels g*LANES .. g*LANES+LANES-1. Lanes past INPUT_CHANNELS-1 in the last group contribute 0.
- FSM:
  - IDLE: ReadyOut_SO=1. On ValidIn_SI, latch channels, mode, label and mask; load the CA with CA_SEED; clear the group counter; go to ACCUM.
  - ACCUM: one group per cycle. The first group overwrites the accumulators; later groups add. The counter and CA advance each cycle. After group G-1, go to THRESH.
  - THRESH: register the thresholded hypervector to the output; go to OUT.
  - OUT: ValidOut_SO=1. Outputs stay stable until ReadyIn_SI.
    - If ReadyIn_SI=1 and ValidIn_SI=1 in the same cycle, ReadyOut_SO=1 (combinational on ReadyIn_SI in OUT only), the new frame is captured and the next state is ACCUM.
    - ReadyIn_SI=1 alone returns to IDLE.
- Latency: capture edge to ValidOut_SO high = G+1 cycles. Throughput = one frame per G+2 cycles.
- Held inputs: ChannelsIn_DI, mode, label and mask changes during ACCUM, THRESH or OUT are ignored. Only the captured copies are used.
- Reset mid-frame: the frame is aborted and no ValidOut_SO is produced.
- ReadyIn_SI is ignored outside OUT.

Optional Feature:
- SPATIAL_MASK_EN defined:
  - ChannelMask_SI exists and is latched with the frame.
  - A masked channel contributes 0, but the CA still advances for it, so channel-to-item mapping is unchanged.
  - All-masked frame: every sum is 0, output is all zeros.
- SPATIAL_MASK_EN undefined: the port is absent and all channels are active.

Test Plan:
- D=8, 2 channels, LANES=1, seed = bit0. Features 3,5. IM_1 = bits 1 and 7 set.
  -> HypervectorOut bits 1 and 7 = 1, all others 0. ValidOut_SO 3 cycles after capture.
- Same frame with LANES=2 -> identical hypervector, ValidOut_SO 2 cycles after capture.
- ReadyIn_SI held 0 for 10 cycles in OUT -> outputs, mode and label stable; ReadyOut_SO=0; ValidIn_SI pulses ignored.
- Back-to-back: ValidIn_SI=1 with ReadyIn_SI=1 in OUT -> second frame captured that cycle, its result appears G+1 cycles later, no idle cycle.
- SPATIAL_MASK_EN, mask=2'b10, features 3,5 -> bits 1 and 7 = 1 (+5), all others 0.
  - mask=2'b00 -> all-zero hypervector.
- Reset_RBI asserted during ACCUM -> ValidOut_SO=0 and outputs zero immediately; the next frame encodes correctly from seed.
